// File: rtl/tron_ctrl_pkg.sv
// Purpose: shared state encodings, opcode constants and defaults for the Tron control sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tron_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  // Opcode values shared with the instruction decoder (ir[15:12]).
  localparam logic [3:0] OP_CMP  = 4'b0110;
  localparam logic [3:0] OP_CMPI = 4'b1011;
  localparam logic [3:0] OP_NOP  = 4'b1110;

  localparam int FETCH_TIMEOUT_DEF = 64;
  localparam int SHIFT_LAT_DEF     = 2;

  // Compare-class instructions are the only ones that update PSR flags.
  function automatic logic is_cmp(input logic [3:0] op);
    return (op == OP_CMP) || (op == OP_CMPI);
  endfunction

endpackage

// File: rtl/tron_wait_counter.sv
// Purpose: loadable down-counter with zero flag and one-cycle-ahead zero lookahead.
// Latency: load/decrement take effect on the next clk edge; flags are combinational.
// Backpressure: none; saturates at zero when decremented further.
module tron_wait_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         zero_nxt
);

  logic [W-1:0] cnt_q;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero     = (cnt_q == '0);
  // Value the zero flag will have after the coming edge, for registered lookahead outputs.
  assign zero_nxt = load ? (load_val == '0) : (dec ? (cnt_q <= W'(1)) : (cnt_q == '0));

endmodule

// File: rtl/tron_ctrl_fsm.sv
// Purpose: multicycle fetch/decode/execute/writeback sequencer for the Tron 16-bit datapath.
// Latency: >=4 cycles per instruction (FETCH until ack, DECODE, EXEC 1..SHIFT_LAT, WB); NOP retires from DECODE.
// Backpressure: FETCH holds mem_req until mem_ack, faulting after FETCH_TIMEOUT cycles; run/halt_req only sampled at retire.
module tron_ctrl_fsm
  import tron_ctrl_pkg::*;
#(
  parameter int SHIFT_LAT     = SHIFT_LAT_DEF,
  parameter int FETCH_TIMEOUT = FETCH_TIMEOUT_DEF,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             halt_req,
  input  logic [3:0]       opcode,
  input  logic             dec_reg_write,
  input  logic             dec_shift_en,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             alu_res_load,
  output logic             rf_we,
  output logic             flag_we,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  // One shared wait counter: fetch timeout and shift latency never overlap in time.
  localparam int FT_W = $clog2(FETCH_TIMEOUT);
  localparam int WC_W = (FT_W > 4) ? FT_W : 4;

  state_t            state_q, state_d;
  logic              retire, timeout;
  logic              wc_load, wc_dec, wc_zero, wc_zero_nxt;
  logic [WC_W-1:0]   wc_val;
  logic              alu_d;
  logic              mem_req_q, alu_q, rf_we_q, flag_we_q, busy_q, fault_q;
  logic [CNT_W-1:0]  retired_q;

  // Next-state logic; run/halt_req matter only in IDLE and at the retire point.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    timeout = 1'b0;
    case (state_q)
      ST_IDLE:   if (run && !fault_q) state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ack) begin
          state_d = ST_DECODE;
        end else if (wc_zero) begin
          state_d = ST_FAULT;
          timeout = 1'b1;
        end
      end
      ST_DECODE: begin
        if (opcode == OP_NOP) retire = 1'b1;
        else                  state_d = ST_EXEC;
      end
      ST_EXEC:   if (!dec_shift_en || wc_zero) state_d = ST_WB;
      ST_WB:     retire = 1'b1;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_IDLE;
    endcase
    if (retire) state_d = (halt_req || !run) ? ST_IDLE : ST_FETCH;
  end

  // Counter reloads on entry to FETCH (timeout) or EXEC (shift latency).
  assign wc_load = ((state_d == ST_FETCH) && (state_q != ST_FETCH)) ||
                   ((state_d == ST_EXEC)  && (state_q != ST_EXEC));
  assign wc_val  = (state_d == ST_EXEC) ? WC_W'(SHIFT_LAT - 1) : WC_W'(FETCH_TIMEOUT - 1);
  assign wc_dec  = (state_q == ST_FETCH) || (state_q == ST_EXEC);

  tron_wait_counter #(.W(WC_W)) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (wc_load),
    .load_val (wc_val),
    .dec      (wc_dec),
    .zero     (wc_zero),
    .zero_nxt (wc_zero_nxt)
  );

  // Result capture lands in the last EXEC cycle: immediately for ALU ops, when the shift count expires otherwise.
  assign alu_d = (state_d == ST_EXEC) && (!dec_shift_en || wc_zero_nxt);

  // State and registered strobes, computed from the upcoming state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mem_req_q <= 1'b0;
      alu_q     <= 1'b0;
      rf_we_q   <= 1'b0;
      flag_we_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= (state_d == ST_FETCH);
      alu_q     <= alu_d;
      rf_we_q   <= (state_d == ST_WB) && dec_reg_write;
      flag_we_q <= (state_d == ST_WB) && is_cmp(opcode);
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  // Sticky fault and free-running retired-instruction count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      if (timeout) fault_q   <= 1'b1;
      if (retire)  retired_q <= retired_q + CNT_W'(1);
    end
  end

  // IR capture and PC bump happen in the ack cycle itself.
  assign ir_load      = (state_q == ST_FETCH) && mem_ack;
  assign pc_inc       = (state_q == ST_FETCH) && mem_ack;
  assign mem_req      = mem_req_q;
  assign alu_res_load = alu_q;
  assign rf_we        = rf_we_q;
  assign flag_we      = flag_we_q;
  assign busy         = busy_q;
  assign fault        = fault_q;
  assign state_o      = state_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_tron_ctrl_fsm.sv
// Purpose: self-checking bench for tron_ctrl_fsm (vector table, corner sequences, randomized reference model).
// Latency: n/a.
// Backpressure: n/a.
module tb_tron_ctrl_fsm;

  localparam int SL = 2;
  localparam int FT = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0, halt_req = 1'b0;
  logic [3:0]    opcode = 4'd0;
  logic          dec_reg_write = 1'b0, dec_shift_en = 1'b0, mem_ack = 1'b0;
  logic          mem_req, ir_load, pc_inc, alu_res_load, rf_we, flag_we, busy, fault;
  logic [2:0]    state_o;
  logic [CW-1:0] retired;

  tron_ctrl_fsm #(.SHIFT_LAT(SL), .FETCH_TIMEOUT(FT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .halt_req(halt_req), .opcode(opcode),
    .dec_reg_write(dec_reg_write), .dec_shift_en(dec_shift_en), .mem_ack(mem_ack),
    .mem_req(mem_req), .ir_load(ir_load), .pc_inc(pc_inc), .alu_res_load(alu_res_load),
    .rf_we(rf_we), .flag_we(flag_we), .busy(busy), .fault(fault), .state_o(state_o),
    .retired(retired)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Observed outputs packed as {state,mem_req,ir_load,pc_inc,alu,rf_we,flag_we,busy,fault,retired}.
  function automatic logic [15:0] snap();
    return {state_o, mem_req, ir_load, pc_inc, alu_res_load, rf_we, flag_we, busy, fault, retired};
  endfunction

  typedef struct packed {
    logic        run;
    logic        halt;
    logic [3:0]  op;
    logic        rw;
    logic        sh;
    logic        ack;
    logic [15:0] exp;
  } vec_t;

  function automatic vec_t mk(input int r, h, op, rw, sh, ack, st, mq, il, al, rf, fl, bz, rt);
    vec_t v;
    v.run  = r[0];
    v.halt = h[0];
    v.op   = op[3:0];
    v.rw   = rw[0];
    v.sh   = sh[0];
    v.ack  = ack[0];
    v.exp  = {st[2:0], mq[0], il[0], il[0], al[0], rf[0], fl[0], bz[0], 1'b0, rt[3:0]};
    return v;
  endfunction

  vec_t tbl[23];

  // Reference model: spec-level phase plus elapsed-cycle count within the phase.
  int m_st, m_ph, m_ret;
  bit m_fault;

  task automatic model_reset();
    m_st = 0; m_ph = 0; m_ret = 0; m_fault = 1'b0;
  endtask

  function automatic logic [15:0] model_out();
    logic [2:0] st;
    logic mq, il, al, rf, fl, bz;
    st = 3'(m_st);
    mq = (m_st == 1);
    il = (m_st == 1) && mem_ack;
    al = (m_st == 3) && (!dec_shift_en || (m_ph == SL - 1));
    rf = (m_st == 4) && dec_reg_write;
    fl = (m_st == 4) && ((opcode == 4'd6) || (opcode == 4'd11));
    bz = (m_st != 0);
    return {st, mq, il, il, al, rf, fl, bz, m_fault, m_ret[3:0]};
  endfunction

  task automatic model_step();
    bit do_ret;
    do_ret = 1'b0;
    case (m_st)
      0: if (run && !m_fault) begin m_st = 1; m_ph = 0; end
      1: begin
        if (mem_ack) m_st = 2;
        else begin
          m_ph++;
          if (m_ph == FT) begin m_st = 5; m_fault = 1'b1; end
        end
      end
      2: if (opcode == 4'd14) do_ret = 1'b1; else begin m_st = 3; m_ph = 0; end
      3: if (!dec_shift_en || (m_ph == SL - 1)) m_st = 4; else m_ph++;
      4: do_ret = 1'b1;
      default: ;
    endcase
    if (do_ret) begin
      m_ret = (m_ret + 1) % (1 << CW);
      m_st  = (halt_req || !run) ? 0 : 1;
      m_ph  = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0; halt_req = 1'b0; mem_ack = 1'b0;
    opcode = 4'd0; dec_reg_write = 1'b0; dec_shift_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int starve;

    // ADD (halt), shift, CMP, NOP with continuous run, then NOP with run dropped.
    tbl[0]  = mk(0,0, 0,0,0,0, 0,0,0,0,0,0,0,0);
    tbl[1]  = mk(1,0, 0,1,0,0, 0,0,0,0,0,0,0,0);
    tbl[2]  = mk(1,0, 0,1,0,0, 1,1,0,0,0,0,1,0);
    tbl[3]  = mk(1,0, 0,1,0,1, 1,1,1,0,0,0,1,0);
    tbl[4]  = mk(1,1, 0,1,0,0, 2,0,0,0,0,0,1,0);
    tbl[5]  = mk(1,1, 0,1,0,0, 3,0,0,1,0,0,1,0);
    tbl[6]  = mk(1,1, 0,1,0,0, 4,0,0,0,1,0,1,0);
    tbl[7]  = mk(0,0, 0,1,0,0, 0,0,0,0,0,0,0,1);
    tbl[8]  = mk(1,0, 1,1,1,0, 0,0,0,0,0,0,0,1);
    tbl[9]  = mk(1,0, 1,1,1,1, 1,1,1,0,0,0,1,1);
    tbl[10] = mk(1,0, 1,1,1,0, 2,0,0,0,0,0,1,1);
    tbl[11] = mk(1,0, 1,1,1,0, 3,0,0,0,0,0,1,1);
    tbl[12] = mk(1,0, 1,1,1,0, 3,0,0,1,0,0,1,1);
    tbl[13] = mk(1,0, 1,1,1,0, 4,0,0,0,1,0,1,1);
    tbl[14] = mk(1,0, 6,0,0,1, 1,1,1,0,0,0,1,2);
    tbl[15] = mk(1,0, 6,0,0,0, 2,0,0,0,0,0,1,2);
    tbl[16] = mk(1,0, 6,0,0,0, 3,0,0,1,0,0,1,2);
    tbl[17] = mk(1,0, 6,0,0,0, 4,0,0,0,0,1,1,2);
    tbl[18] = mk(1,0,14,0,0,1, 1,1,1,0,0,0,1,3);
    tbl[19] = mk(1,0,14,0,0,0, 2,0,0,0,0,0,1,3);
    tbl[20] = mk(1,0,14,0,0,1, 1,1,1,0,0,0,1,4);
    tbl[21] = mk(0,0,14,0,0,0, 2,0,0,0,0,0,1,4);
    tbl[22] = mk(0,0, 0,0,0,0, 0,0,0,0,0,0,0,5);

    do_reset();
    #1 chk("reset", 32'(snap()), 32'h0);

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      run = tbl[i].run; halt_req = tbl[i].halt; opcode = tbl[i].op;
      dec_reg_write = tbl[i].rw; dec_shift_en = tbl[i].sh; mem_ack = tbl[i].ack;
      #1 chk($sformatf("vec[%0d]", i), 32'(snap()), 32'(tbl[i].exp));
    end

    // Fetch timeout: 64 FETCH cycles without ack, then sticky FAULT.
    do_reset();
    @(negedge clk); run = 1'b1;
    for (int k = 1; k <= FT; k++) begin
      @(negedge clk);
      #1 if (k == FT) chk("fetch_last_wait", 32'({state_o, mem_req, fault}), 32'({3'd1, 1'b1, 1'b0}));
    end
    @(negedge clk);
    #1 chk("fault_entry", 32'(snap()), 32'({3'd5, 7'b0000001, 1'b1, 4'd0}));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); mem_ack = 1'b1; run = k[0];
      #1 chk("fault_hold", 32'({state_o, ir_load, mem_req, busy, fault}), 32'({3'd5, 4'b0011}));
    end
    rst_n = 1'b0;
    #1 chk("fault_rst", 32'(snap()), 32'h0);
    @(negedge clk); rst_n = 1'b1; mem_ack = 1'b0; run = 1'b0;

    // Ack on the timeout cycle wins over the fault.
    do_reset();
    @(negedge clk); run = 1'b1; halt_req = 1'b1;
    for (int k = 1; k <= FT; k++) begin
      @(negedge clk); mem_ack = (k == FT);
      #1 if (k == FT) chk("ack_at_limit", 32'({state_o, ir_load, pc_inc}), 32'({3'd1, 2'b11}));
    end
    @(negedge clk); mem_ack = 1'b0;
    #1 chk("ack_wins", 32'({state_o, fault}), 32'({3'd2, 1'b0}));
    repeat (3) @(negedge clk);
    #1 chk("ack_wins_retire", 32'({state_o, retired}), 32'({3'd0, 4'd1}));

    // Retired counter wrap with back-to-back NOPs.
    do_reset();
    @(negedge clk); run = 1'b1; opcode = 4'd14; mem_ack = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      #1;
      if (i == 31) chk("pre_wrap", 32'({state_o, retired}), 32'({3'd1, 4'd15}));
      if (i == 32) chk("wrap_no_stall", 32'(state_o), 32'd2);
      if (i == 33) chk("wrap", 32'({state_o, retired}), 32'({3'd1, 4'd0}));
    end

    // Reset dropped mid-EXEC of a shift instruction.
    do_reset();
    @(negedge clk); run = 1'b1; opcode = 4'd14; mem_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); opcode = 4'd1; dec_shift_en = 1'b1; dec_reg_write = 1'b1;
    @(negedge clk); mem_ack = 1'b0;
    @(negedge clk);
    #1 chk("pre_rst", 32'({state_o, retired}), 32'({3'd3, 4'd1}));
    rst_n = 1'b0;
    #1 chk("rst_exec", 32'(snap()), 32'h0);
    @(negedge clk); rst_n = 1'b1; run = 1'b1;
    @(negedge clk);
    #1 chk("restart", 32'({state_o, mem_req, busy}), 32'({3'd1, 2'b11}));

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    starve = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if (($urandom_range(0, 399) == 0) || ((m_st == 5) && ($urandom_range(0, 19) == 0))) begin
        rst_n = 1'b0;
        model_reset();
        #1 chk("rand_rst", 32'(snap()), 32'(model_out()));
        continue;
      end
      run      = ($urandom_range(0, 99) < 85);
      halt_req = ($urandom_range(0, 99) < 15);
      if (starve > 0) begin
        starve--;
        mem_ack = 1'b0;
      end else begin
        mem_ack = ($urandom_range(0, 99) < 60);
        if ($urandom_range(0, 599) == 0) starve = 70;
      end
      if ((m_st == 0) || (m_st == 1)) begin
        opcode        = 4'($urandom_range(0, 15));
        dec_reg_write = 1'($urandom_range(0, 1));
        dec_shift_en  = ($urandom_range(0, 2) == 0);
      end
      #1 chk($sformatf("rand[%0d]", c), 32'(snap()), 32'(model_out()));
      model_step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
